// File: rtl/matrix_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_mult_pkg : shared state encoding and address-width helper     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package matrix_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_MAC    = 3'd3,
        ST_OUT    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Index width for a store of the given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_mult_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_mult_ctrl_if : operand-store, MAC and status strobes          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface matrix_mult_ctrl_if
    import matrix_mult_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2
) ();
    localparam int AW = addr_w(M * N);
    localparam int CW = addr_w(M * M);

    logic          start;
    logic          in_valid;
    logic          a_wr;
    logic          b_wr;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          c_valid;
    logic [CW-1:0] c_addr;
    logic          busy;
    logic          done;

    modport master (
        input  start, in_valid,
        output a_wr, b_wr, a_addr, b_addr, mac_en, mac_clr, c_valid, c_addr, busy, done
    );

    modport slave (
        output start, in_valid,
        input  a_wr, b_wr, a_addr, b_addr, mac_en, mac_clr, c_valid, c_addr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mm_idx_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mm_idx_counter : nested i/j/k counter sequencing the MAC/OUT phases  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mm_idx_counter
    import matrix_mult_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   k_en_i,
    input  logic                   ij_en_i,
    output logic [addr_w(M)-1:0]   i_o,
    output logic [addr_w(M)-1:0]   j_o,
    output logic [addr_w(N)-1:0]   k_o,
    output logic                   k_last_o,
    output logic                   j_last_o,
    output logic                   i_last_o
);
    localparam int IW = addr_w(M);
    localparam int KW = addr_w(N);

    logic [IW-1:0] i_q, i_d, j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    assign k_last_o = (k_q == KW'(N - 1));
    assign j_last_o = (j_q == IW'(M - 1));
    assign i_last_o = (i_q == IW'(M - 1));
    assign i_o      = i_q;
    assign j_o      = j_q;
    assign k_o      = k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    // j is the fast output index; i advances only when j wraps.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else begin
            if (k_en_i) begin
                k_d = k_last_o ? '0 : k_q + KW'(1);
            end
            if (ij_en_i) begin
                if (j_last_o) begin
                    j_d = '0;
                    i_d = i_last_o ? '0 : i_q + IW'(1);
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/matrix_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_mult_ctrl : sequencer for C = A x B (load A, load B, MAC/OUT) |
// | Optional macro MM_CTRL_VALID_EN: loads advance only on in_valid.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module matrix_mult_ctrl
    import matrix_mult_pkg::*;
#(
    parameter int DW = 8,
    parameter int M  = 2,
    parameter int N  = 2
) (
    input  logic               clk,
    input  logic               reset,
    matrix_mult_ctrl_if.master bus
);
    localparam int            AW       = addr_w(M * N);
    localparam int            CW       = addr_w(M * M);
    localparam int            IW       = addr_w(M);
    localparam int            KW       = addr_w(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(M * N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          accept;
    logic [IW-1:0] i_cnt, j_cnt;
    logic [KW-1:0] k_cnt;
    logic          k_last, j_last, i_last;
    logic          a_wr, b_wr, c_valid;

    // DW only sizes the external operand stores.
    if (DW < 1) begin : g_dw_invalid
    end

`ifdef MM_CTRL_VALID_EN
    // Write strobes follow in_valid in the same cycle so each element is captured as presented.
    assign accept = bus.in_valid;
`else
    logic unused_in_valid;
    assign unused_in_valid = bus.in_valid;
    assign accept          = 1'b1;
`endif

    mm_idx_counter #(.M(M), .N(N)) u_idx (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (state_q == ST_IDLE),
        .k_en_i   (state_q == ST_MAC),
        .ij_en_i  (state_q == ST_OUT),
        .i_o      (i_cnt),
        .j_o      (j_cnt),
        .k_o      (k_cnt),
        .k_last_o (k_last),
        .j_last_o (j_last),
        .i_last_o (i_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.start) state_d = ST_LOAD_A;
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_MAC;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_MAC:  if (k_last) state_d = ST_OUT;
            ST_OUT:  state_d = (i_last && j_last) ? ST_DONE : ST_MAC;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign a_wr    = (state_q == ST_LOAD_A) && accept;
    assign b_wr    = (state_q == ST_LOAD_B) && accept;
    assign c_valid = (state_q == ST_OUT);

    assign bus.a_wr    = a_wr;
    assign bus.b_wr    = b_wr;
    assign bus.a_addr  = a_wr ? idx_q : '0;
    assign bus.b_addr  = b_wr ? idx_q : '0;
    assign bus.mac_en  = (state_q == ST_MAC);
    assign bus.mac_clr = (state_q == ST_MAC) && (k_cnt == '0);
    assign bus.c_valid = c_valid;
    assign bus.c_addr  = c_valid ? CW'(int'(i_cnt) * M + int'(j_cnt)) : '0;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
endmodule
`default_nettype wire
